// File: rtl/ps2_command_scheduler.sv
// PS/2 host-to-keyboard Set-LEDs sequencer: sends 0xED then the LED byte, waiting for ACK after each.
// Optional ACK timeout enabled by defining PS2_CMD_TIMEOUT_EN.
module ps2_command_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 2_700_000,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_status,
   input  logic       status_caps_lock,
   input  logic       status_num_lock,
   input  logic       status_scroll_lock,
   input  logic       acknowledge,
   input  logic       resend,
   input  logic       tx_ready,
   output logic       tx_valid,
   output logic [7:0] tx_byte,
   output logic       busy,
   output logic       error
);

   localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
   localparam logic [RetryW-1:0] RetryLimit = RetryW'(MAX_RETRIES);
   localparam logic [7:0] CmdSetLeds = 8'hED;

   // Elaboration-time guard against degenerate configurations
   if (MAX_RETRIES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("ps2_command_scheduler: MAX_RETRIES must be >= 1 and TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEND_CMD = 3'd1,
      WAIT_CMD = 3'd2,
      SEND_LED = 3'd3,
      WAIT_LED = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic              pending_q, pending_d;
   logic [2:0]        led_reg_q, led_reg_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              busy_q, busy_d;
   logic              error_q, error_d;
   logic [RetryW-1:0] retry_inc_c;
   logic              timeout_c;

`ifdef PS2_CMD_TIMEOUT_EN
   localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

   logic [TimerW-1:0] timer_q, timer_d;
   logic              waiting_c;

   assign waiting_c = (state_q == WAIT_CMD) || (state_q == WAIT_LED);
   assign timeout_c = waiting_c && (timer_q == TimerLast);

   // Timer restarts while a byte is offered and counts every cycle spent awaiting ACK
   always_comb begin
      timer_d = '0;
      if (waiting_c && !timeout_c) begin
         timer_d = timer_q + TimerW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign timeout_c = 1'b0;
`endif

   assign retry_inc_c = retry_q + RetryW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pending_q  <= 1'b0;
         led_reg_q  <= 3'b000;
         retry_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_byte_q  <= 8'h00;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         led_reg_q  <= led_reg_d;
         retry_q    <= retry_d;
         tx_valid_q <= tx_valid_d;
         tx_byte_q  <= tx_byte_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      led_reg_d  = led_reg_q;
      retry_d    = retry_q;
      tx_valid_d = tx_valid_q;
      tx_byte_d  = tx_byte_q;
      error_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pending_q) begin
               state_d    = SEND_CMD;
               pending_d  = 1'b0;
               retry_d    = '0;
               tx_valid_d = 1'b1;
               tx_byte_d  = CmdSetLeds;
            end
         end
         SEND_CMD, SEND_LED: begin
            if (tx_valid_q && tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = (state_q == SEND_CMD) ? WAIT_CMD : WAIT_LED;
            end
         end
         WAIT_CMD, WAIT_LED: begin
            // ACK has priority over a simultaneous resend/timeout
            if (acknowledge) begin
               retry_d = '0;
               if (state_q == WAIT_CMD) begin
                  state_d    = SEND_LED;
                  tx_valid_d = 1'b1;
                  tx_byte_d  = {5'b00000, led_reg_q};
               end else begin
                  state_d = IDLE;
               end
            end else if (resend || timeout_c) begin
               if (retry_inc_c == RetryLimit) begin
                  error_d = 1'b1;
                  retry_d = '0;
                  state_d = IDLE;
               end else begin
                  retry_d    = retry_inc_c;
                  tx_valid_d = 1'b1;
                  state_d    = (state_q == WAIT_CMD) ? SEND_CMD : SEND_LED;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
         end
      endcase

      // A new request always wins over the start-of-sequence clear
      if (set_status) begin
         pending_d = 1'b1;
         led_reg_d = {status_caps_lock, status_num_lock, status_scroll_lock};
      end

      busy_d = (state_d != IDLE);
   end

   assign tx_valid = tx_valid_q;
   assign tx_byte  = tx_byte_q;
   assign busy     = busy_q;
   assign error    = error_q;

endmodule
